// File: rtl/id_issue_stage.sv
// Decode/issue stage: register file, EX/MEM/WB operand bypass, load-use stall
// and an elastic ID/EX register with valid/ready on both sides.
module id_issue_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 32,
  parameter int FWD_EN = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [AW-1:0]     id_rs1_addr_i,
  input  logic [AW-1:0]     id_rs2_addr_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [AW-1:0]     id_rd_addr_i,
  input  logic              id_rd_we_i,
  input  logic              id_is_load_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [XLEN-1:0]   ex_rs1_rdata_o,
  output logic [XLEN-1:0]   ex_rs2_rdata_o,
  output logic [AW-1:0]     ex_rd_addr_o,
  output logic              ex_rd_we_o,
  output logic              ex_is_load_o,
  input  logic [XLEN-1:0]   ex_fwd_data_i,
  input  logic              mem_fwd_valid_i,
  input  logic [AW-1:0]     mem_fwd_addr_i,
  input  logic [XLEN-1:0]   mem_fwd_data_i,
  input  logic              wb_we_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              flush_i
);

  logic [XLEN-1:0]   rf_q [NREGS];
  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [XLEN-1:0]   ex_rs1_q, ex_rs2_q;
  logic [AW-1:0]     ex_rd_addr_q;
  logic              ex_rd_we_q;
  logic              ex_is_load_q;
  logic [XLEN-1:0]   rs1_rdata, rs2_rdata;
  logic              hazard, id_ready, ex_load;

  function automatic logic ex_writes(input logic [AW-1:0] a);
    return ex_valid_q && ex_rd_we_q && (ex_rd_addr_q == a);
  endfunction

  // Later assignments override earlier ones, giving x0 > EX > MEM > WB > RF.
  function automatic logic [XLEN-1:0] operand(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = rf_q[a];
    if (wb_we_i && (wb_addr_i == a)) v = wb_data_i;
    if ((FWD_EN != 0) && mem_fwd_valid_i && (mem_fwd_addr_i == a)) v = mem_fwd_data_i;
    if ((FWD_EN != 0) && ex_writes(a) && !ex_is_load_q) v = ex_fwd_data_i;
    if (a == '0) v = '0;
    return v;
  endfunction

  function automatic logic src_hazard(input logic used, input logic [AW-1:0] a);
    logic h;
    h = 1'b0;
    if (used && (a != '0)) begin
      if (ex_writes(a) && ex_is_load_q) h = 1'b1;
      if ((FWD_EN == 0) && (ex_writes(a) || (mem_fwd_valid_i && (mem_fwd_addr_i == a)))) h = 1'b1;
    end
    return h;
  endfunction

  always_comb begin
    rs1_rdata  = operand(id_rs1_addr_i);
    rs2_rdata  = operand(id_rs2_addr_i);
    hazard     = id_valid_i && (src_hazard(id_rs1_use_i, id_rs1_addr_i) ||
                                src_hazard(id_rs2_use_i, id_rs2_addr_i));
    id_ready   = flush_i || (!hazard && (!ex_valid_q || ex_ready_i));
    ex_load    = 1'b0;
    ex_valid_d = ex_valid_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (id_valid_i && id_ready) begin
      ex_valid_d = 1'b1;
      ex_load    = 1'b1;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we_i && (wb_addr_i != '0)) begin
      rf_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_ctrl_q    <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_addr_q <= '0;
      ex_rd_we_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (ex_load) begin
        ex_pc_q      <= id_pc_i;
        ex_ctrl_q    <= id_ctrl_i;
        ex_rs1_q     <= rs1_rdata;
        ex_rs2_q     <= rs2_rdata;
        ex_rd_addr_q <= id_rd_addr_i;
        ex_rd_we_q   <= id_rd_we_i;
        ex_is_load_q <= id_is_load_i;
      end
    end
  end

  assign id_ready_o     = id_ready;
  assign ex_valid_o     = ex_valid_q;
  assign ex_pc_o        = ex_pc_q;
  assign ex_ctrl_o      = ex_ctrl_q;
  assign ex_rs1_rdata_o = ex_rs1_q;
  assign ex_rs2_rdata_o = ex_rs2_q;
  assign ex_rd_addr_o   = ex_rd_addr_q;
  assign ex_rd_we_o     = ex_rd_we_q;
  assign ex_is_load_o   = ex_is_load_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: three instances (RV32I bypass, RV32I no-bypass, RV32E)
// share one stimulus; each phase checks the instance it targets.
module tb_id_issue_stage;

  logic        clk, rst;
  logic        id_valid, use1, use2, rd_we, is_load, ex_ready, flush;
  logic [31:0] id_pc, id_ctrl, ex_fwd, mem_data, wb_data;
  logic [4:0]  rs1, rs2, rd, mem_addr, wb_addr;
  logic        mem_v, wb_we;

  logic        a_ready, a_valid, a_we, a_ld;
  logic [31:0] a_pc, a_ctrl, a_rs1, a_rs2;
  logic [4:0]  a_rd;
  logic        n_ready, n_valid, n_we, n_ld;
  logic [31:0] n_pc, n_ctrl, n_rs1, n_rs2;
  logic [4:0]  n_rd;
  logic        e_ready, e_valid, e_we, e_ld;
  logic [31:0] e_pc, e_ctrl, e_rs1, e_rs2;
  logic [3:0]  e_rd;

  int total = 0;
  int bad   = 0;

  id_issue_stage #(.XLEN(32), .NREGS(32), .CTRL_W(32), .FWD_EN(1)) u_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(a_ready),
    .id_pc_i(id_pc), .id_ctrl_i(id_ctrl), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_use_i(use1), .id_rs2_use_i(use2), .id_rd_addr_i(rd), .id_rd_we_i(rd_we),
    .id_is_load_i(is_load), .ex_valid_o(a_valid), .ex_ready_i(ex_ready), .ex_pc_o(a_pc),
    .ex_ctrl_o(a_ctrl), .ex_rs1_rdata_o(a_rs1), .ex_rs2_rdata_o(a_rs2), .ex_rd_addr_o(a_rd),
    .ex_rd_we_o(a_we), .ex_is_load_o(a_ld), .ex_fwd_data_i(ex_fwd),
    .mem_fwd_valid_i(mem_v), .mem_fwd_addr_i(mem_addr), .mem_fwd_data_i(mem_data),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .flush_i(flush));

  id_issue_stage #(.XLEN(32), .NREGS(32), .CTRL_W(32), .FWD_EN(0)) u_n (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(n_ready),
    .id_pc_i(id_pc), .id_ctrl_i(id_ctrl), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_use_i(use1), .id_rs2_use_i(use2), .id_rd_addr_i(rd), .id_rd_we_i(rd_we),
    .id_is_load_i(is_load), .ex_valid_o(n_valid), .ex_ready_i(ex_ready), .ex_pc_o(n_pc),
    .ex_ctrl_o(n_ctrl), .ex_rs1_rdata_o(n_rs1), .ex_rs2_rdata_o(n_rs2), .ex_rd_addr_o(n_rd),
    .ex_rd_we_o(n_we), .ex_is_load_o(n_ld), .ex_fwd_data_i(ex_fwd),
    .mem_fwd_valid_i(mem_v), .mem_fwd_addr_i(mem_addr), .mem_fwd_data_i(mem_data),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .flush_i(flush));

  id_issue_stage #(.XLEN(32), .NREGS(16), .CTRL_W(32), .FWD_EN(1)) u_e (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(e_ready),
    .id_pc_i(id_pc), .id_ctrl_i(id_ctrl), .id_rs1_addr_i(rs1[3:0]), .id_rs2_addr_i(rs2[3:0]),
    .id_rs1_use_i(use1), .id_rs2_use_i(use2), .id_rd_addr_i(rd[3:0]), .id_rd_we_i(rd_we),
    .id_is_load_i(is_load), .ex_valid_o(e_valid), .ex_ready_i(ex_ready), .ex_pc_o(e_pc),
    .ex_ctrl_o(e_ctrl), .ex_rs1_rdata_o(e_rs1), .ex_rs2_rdata_o(e_rs2), .ex_rd_addr_o(e_rd),
    .ex_rd_we_o(e_we), .ex_is_load_o(e_ld), .ex_fwd_data_i(ex_fwd),
    .mem_fwd_valid_i(mem_v), .mem_fwd_addr_i(mem_addr[3:0]), .mem_fwd_data_i(mem_data),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr[3:0]), .wb_data_i(wb_data), .flush_i(flush));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, rd_we, is_load;
    logic        mem_v;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] ex_fwd;
    logic [31:0] exp_rs1, exp_rs2;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; use1 = 0; use2 = 0; rd_we = 0; is_load = 0; flush = 0;
    rs1 = 0; rs2 = 0; rd = 0; mem_v = 0; mem_addr = 0; mem_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; ex_fwd = 0; ex_ready = 1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] d,
                       input logic we, input logic ld);
    id_valid = 1; id_pc = pc; id_ctrl = pc ^ 32'hC0DE_0000;
    rs1 = r1; use1 = u1; rs2 = r2; use2 = u2; rd = d; rd_we = we; is_load = ld;
  endtask

  initial begin
    // rs1, rs2, rd, use1, use2, we, load, mem_v, mem_addr, mem_data, wb_we, wb_addr, wb_data, ex_fwd, exp_rs1, exp_rs2
    tbl[0] = '{5, 6, 3, 1, 1, 1, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 32'h1234, 0};
    tbl[1] = '{5, 3, 7, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'hDEAD, 32'h1234, 32'hDEAD};
    tbl[2] = '{3, 9, 0, 1, 1, 1, 0, 1, 3, 32'hBEEF, 1, 9, 32'h9999, 32'h0BAD, 32'hBEEF, 32'h9999};
    tbl[3] = '{0, 9, 11, 1, 1, 1, 0, 1, 0, 32'h5555, 1, 0, 32'hFFFF_FFFF, 32'hAAAA, 0, 32'h9999};
    tbl[4] = '{11, 5, 12, 1, 1, 0, 0, 1, 11, 32'h2222, 1, 11, 32'h3333, 32'h1111, 32'h1111, 32'h1234};
    tbl[5] = '{12, 0, 13, 1, 1, 1, 0, 1, 12, 32'h4444, 1, 12, 32'h5555, 32'h7777, 32'h4444, 0};
    tbl[6] = '{12, 13, 14, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h6666, 32'h5555, 32'h6666};
    tbl[7] = '{11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3333, 0};

    idle();
    id_pc = 0; id_ctrl = 0;
    rst = 1;
    id_valid = 1;
    step();
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_rd", 32'(a_rd), 0);
    chk("rst_rs1", a_rs1, 0);
    step();
    rst = 0;
    idle();
    step();
    chk("idle_valid", 32'(a_valid), 0);

    for (int i = 0; i < 8; i++) begin
      issue(32'(i * 4), tbl[i].rs1, tbl[i].use1, tbl[i].rs2, tbl[i].use2,
            tbl[i].rd, tbl[i].rd_we, tbl[i].is_load);
      mem_v = tbl[i].mem_v; mem_addr = tbl[i].mem_addr; mem_data = tbl[i].mem_data;
      wb_we = tbl[i].wb_we; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
      ex_fwd = tbl[i].ex_fwd;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(a_ready), 1);
      step();
      chk($sformatf("v%0d_valid", i), 32'(a_valid), 1);
      chk($sformatf("v%0d_pc", i), a_pc, 32'(i * 4));
      chk($sformatf("v%0d_ctrl", i), a_ctrl, 32'(i * 4) ^ 32'hC0DE_0000);
      chk($sformatf("v%0d_rs1", i), a_rs1, tbl[i].exp_rs1);
      if (tbl[i].use2) chk($sformatf("v%0d_rs2", i), a_rs2, tbl[i].exp_rs2);
      chk($sformatf("v%0d_rd", i), 32'(a_rd), 32'(tbl[i].rd));
      chk($sformatf("v%0d_ld", i), 32'(a_ld), 32'(tbl[i].is_load));
    end

    // load-use: one bubble, then MEM forwarding of load data
    idle();
    issue(32'h40, 0, 0, 0, 0, 7, 1, 1);
    step();
    issue(32'h44, 7, 1, 0, 0, 8, 1, 0);
    @(negedge clk);
    chk("lu_ready_stall", 32'(a_ready), 0);
    step();
    chk("lu_bubble", 32'(a_valid), 0);
    mem_v = 1; mem_addr = 7; mem_data = 32'hCAFE;
    @(negedge clk);
    chk("lu_ready_go", 32'(a_ready), 1);
    step();
    chk("lu_valid", 32'(a_valid), 1);
    chk("lu_pc", a_pc, 32'h44);
    chk("lu_rs1", a_rs1, 32'hCAFE);
    mem_v = 0;

    // backpressure for 3 cycles, then release
    issue(32'h48, 5, 1, 0, 0, 9, 1, 0);
    ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", k), 32'(a_ready), 0);
      step();
      chk($sformatf("bp%0d_valid", k), 32'(a_valid), 1);
      chk($sformatf("bp%0d_pc", k), a_pc, 32'h44);
      chk($sformatf("bp%0d_rs1", k), a_rs1, 32'hCAFE);
      chk($sformatf("bp%0d_rd", k), 32'(a_rd), 8);
    end
    ex_ready = 1;
    @(negedge clk);
    chk("bp_rel_ready", 32'(a_ready), 1);
    step();
    chk("bp_rel_pc", a_pc, 32'h48);
    chk("bp_rel_rs1", a_rs1, 32'h1234);

    // flush during backpressure
    issue(32'h4C, 5, 1, 0, 0, 10, 1, 0);
    ex_ready = 0; flush = 1;
    @(negedge clk);
    chk("fl_bp_ready", 32'(a_ready), 1);
    step();
    chk("fl_bp_valid", 32'(a_valid), 0);
    idle();
    step();
    chk("fl_bp_drop", 32'(a_valid), 0);

    // flush during load-use stall
    issue(32'h50, 0, 0, 0, 0, 7, 1, 1);
    step();
    chk("fl_lu_load", a_pc, 32'h50);
    issue(32'h54, 7, 1, 0, 0, 11, 1, 0);
    @(negedge clk);
    chk("fl_lu_stall", 32'(a_ready), 0);
    flush = 1;
    step();
    chk("fl_lu_valid", 32'(a_valid), 0);
    idle();
    step();
    chk("fl_lu_drop", 32'(a_valid), 0);

    // reset mid-stream discards EX contents and the register file
    issue(32'h60, 5, 1, 0, 0, 0, 0, 0);
    step();
    chk("mr_pre_rs1", a_rs1, 32'h1234);
    rst = 1;
    step();
    chk("mr_valid", 32'(a_valid), 0);
    chk("mr_pc", a_pc, 0);
    step();
    chk("mr_valid_hold", 32'(a_valid), 0);
    rst = 0;
    issue(32'h64, 5, 1, 0, 0, 0, 0, 0);
    step();
    chk("mr_rf_clear", a_rs1, 0);
    chk("mr_valid_post", 32'(a_valid), 1);

    // RAW back-to-back: bypass instance forwards, no-bypass instance stalls twice
    issue(32'h100, 0, 0, 0, 0, 3, 1, 0);
    step();
    chk("raw_n_i1", n_pc, 32'h100);
    issue(32'h104, 3, 1, 0, 0, 4, 0, 0);
    ex_fwd = 32'hDEAD;
    @(negedge clk);
    chk("raw_a_ready", 32'(a_ready), 1);
    chk("raw_n_stall0", 32'(n_ready), 0);
    step();
    chk("raw_a_pc", a_pc, 32'h104);
    chk("raw_a_rs1", a_rs1, 32'hDEAD);
    chk("raw_n_bub0", 32'(n_valid), 0);
    mem_v = 1; mem_addr = 3; mem_data = 32'hDEAD;
    @(negedge clk);
    chk("raw_n_stall1", 32'(n_ready), 0);
    step();
    chk("raw_n_bub1", 32'(n_valid), 0);
    mem_v = 0; wb_we = 1; wb_addr = 3; wb_data = 32'h7777;
    @(negedge clk);
    chk("raw_n_go", 32'(n_ready), 1);
    step();
    chk("raw_n_valid", 32'(n_valid), 1);
    chk("raw_n_pc", n_pc, 32'h104);
    chk("raw_n_rs1", n_rs1, 32'h7777);

    // RV32E: x15 write-through, EX forward, register read, load-use
    idle();
    rst = 1;
    step();
    rst = 0;
    issue(32'h200, 15, 1, 0, 0, 15, 1, 0);
    wb_we = 1; wb_addr = 15; wb_data = 32'hE15E;
    step();
    chk("e_wt_rs1", e_rs1, 32'hE15E);
    chk("e_wt_rd", 32'(e_rd), 15);
    wb_we = 0;
    issue(32'h204, 15, 1, 15, 1, 1, 0, 0);
    ex_fwd = 32'hF00F;
    step();
    chk("e_fwd_rs1", e_rs1, 32'hF00F);
    chk("e_fwd_rs2", e_rs2, 32'hF00F);
    ex_fwd = 0;
    issue(32'h208, 15, 1, 0, 0, 15, 1, 1);
    step();
    chk("e_rf_rs1", e_rs1, 32'hE15E);
    issue(32'h20C, 15, 1, 0, 0, 2, 1, 0);
    @(negedge clk);
    chk("e_lu_stall", 32'(e_ready), 0);
    step();
    chk("e_lu_bubble", 32'(e_valid), 0);

    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
